// File: rtl/rv_pipe_pkg.sv
// Shared types and encodings for the 5-stage RV32 pipeline.
// Holds the decoder control bundle and the opcode/ALUOp constants that the stages share.
package rv_pipe_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_LD  = 7'b0000011;
  localparam logic [6:0] OP_I_IMM = 7'b0010011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_U     = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       memRead;
    logic       memToReg;
    logic [1:0] ALUOp;
    logic       memWrite;
    logic       ALUSrc;
    logic       regWrite;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Which action the ID/EX register takes on the coming edge.
  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_FLUSH,
    UPD_BUBBLE,
    UPD_PASS
  } upd_e;

  // rs2 is read from the register file for R-type ops and for stores (store data).
  function automatic logic uses_rs2(input ctrl_t c);
    return !c.ALUSrc | c.memWrite;
  endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// Combinational load-use hazard detector between the EX-stage load and the ID instruction.
// A load targeting x0 never creates a dependency.
module hazard_detect_unit (
  input  logic       ex_valid,
  input  logic       ex_memRead,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       use_rs2,
  output logic       hazard
);

  logic load_in_ex;
  logic rs1_match;
  logic rs2_match;

  assign load_in_ex = ex_valid & ex_memRead & (ex_rd != 5'd0);
  assign rs1_match  = (ex_rd == id_rs1);
  assign rs2_match  = use_rs2 & (ex_rd == id_rs2);
  assign hazard     = load_in_ex & id_valid & (rs1_match | rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and downstream hold.
// Also keeps a saturating count of inserted load-use bubbles.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct,
  input  logic             id_branch,
  input  logic             id_memRead,
  input  logic             id_memToReg,
  input  logic [1:0]       id_ALUOp,
  input  logic             id_memWrite,
  input  logic             id_ALUSrc,
  input  logic             id_regWrite,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct,
  output logic             ex_branch,
  output logic             ex_memRead,
  output logic             ex_memToReg,
  output logic [1:0]       ex_ALUOp,
  output logic             ex_memWrite,
  output logic             ex_ALUSrc,
  output logic             ex_regWrite,
  output logic [CNT_W-1:0] bubble_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ctrl_reg, ctrl_next;
  logic  valid_reg, valid_next;
  logic [XLEN-1:0]  pc_reg, pc_next;
  logic [XLEN-1:0]  rs1_data_reg, rs1_data_next;
  logic [XLEN-1:0]  rs2_data_reg, rs2_data_next;
  logic [XLEN-1:0]  imm_reg, imm_next;
  logic [4:0]       rs1_reg, rs1_next;
  logic [4:0]       rs2_reg, rs2_next;
  logic [4:0]       rd_reg, rd_next;
  logic [3:0]       funct_reg, funct_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hazard;
  upd_e             upd;

  assign id_ctrl = '{
    branch:   id_branch,
    memRead:  id_memRead,
    memToReg: id_memToReg,
    ALUOp:    id_ALUOp,
    memWrite: id_memWrite,
    ALUSrc:   id_ALUSrc,
    regWrite: id_regWrite
  };

  hazard_detect_unit u_hazard (
    .ex_valid   (valid_reg),
    .ex_memRead (ctrl_reg.memRead),
    .ex_rd      (rd_reg),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .use_rs2    (uses_rs2(id_ctrl)),
    .hazard     (hazard)
  );

  // A flushed instruction must not freeze fetch of the branch target.
  assign stall = ex_hold | (hazard & ~flush);

  always_comb begin
    if (ex_hold)     upd = UPD_HOLD;
    else if (flush)  upd = UPD_FLUSH;
    else if (hazard) upd = UPD_BUBBLE;
    else             upd = UPD_PASS;
  end

  always_comb begin
    valid_next    = valid_reg;
    ctrl_next     = ctrl_reg;
    cnt_next      = cnt_reg;
    pc_next       = id_pc;
    rs1_data_next = id_rs1_data;
    rs2_data_next = id_rs2_data;
    imm_next      = id_imm;
    rs1_next      = id_rs1;
    rs2_next      = id_rs2;
    rd_next       = id_rd;
    funct_next    = id_funct;
    case (upd)
      UPD_HOLD: begin
        pc_next       = pc_reg;
        rs1_data_next = rs1_data_reg;
        rs2_data_next = rs2_data_reg;
        imm_next      = imm_reg;
        rs1_next      = rs1_reg;
        rs2_next      = rs2_reg;
        rd_next       = rd_reg;
        funct_next    = funct_reg;
      end
      UPD_FLUSH: begin
        valid_next = 1'b0;
        ctrl_next  = CTRL_NOP;
      end
      UPD_BUBBLE: begin
        valid_next = 1'b0;
        ctrl_next  = CTRL_NOP;
        if (cnt_reg != {CNT_W{1'b1}}) cnt_next = cnt_reg + 1'b1;
      end
      default: begin
        valid_next = id_valid;
        ctrl_next  = id_valid ? id_ctrl : CTRL_NOP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      ctrl_reg     <= CTRL_NOP;
      cnt_reg      <= '0;
      pc_reg       <= '0;
      rs1_data_reg <= '0;
      rs2_data_reg <= '0;
      imm_reg      <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
      funct_reg    <= '0;
    end else begin
      valid_reg    <= valid_next;
      ctrl_reg     <= ctrl_next;
      cnt_reg      <= cnt_next;
      pc_reg       <= pc_next;
      rs1_data_reg <= rs1_data_next;
      rs2_data_reg <= rs2_data_next;
      imm_reg      <= imm_next;
      rs1_reg      <= rs1_next;
      rs2_reg      <= rs2_next;
      rd_reg       <= rd_next;
      funct_reg    <= funct_next;
    end
  end

  assign ex_valid    = valid_reg;
  assign ex_pc       = pc_reg;
  assign ex_rs1_data = rs1_data_reg;
  assign ex_rs2_data = rs2_data_reg;
  assign ex_imm      = imm_reg;
  assign ex_rs1      = rs1_reg;
  assign ex_rs2      = rs2_reg;
  assign ex_rd       = rd_reg;
  assign ex_funct    = funct_reg;
  assign ex_branch   = ctrl_reg.branch;
  assign ex_memRead  = ctrl_reg.memRead;
  assign ex_memToReg = ctrl_reg.memToReg;
  assign ex_ALUOp    = ctrl_reg.ALUOp;
  assign ex_memWrite = ctrl_reg.memWrite;
  assign ex_ALUSrc   = ctrl_reg.ALUSrc;
  assign ex_regWrite = ctrl_reg.regWrite;
  assign bubble_cnt  = cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for the main flow, hand sequences for reset and saturation.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic id_branch, id_memRead, id_memToReg, id_memWrite, id_ALUSrc, id_regWrite;
  logic [1:0]  id_ALUOp;
  logic flush, ex_hold;

  logic stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite;
  logic [1:0]  ex_ALUOp;
  logic [15:0] bubble_cnt;

  logic s_stall, s_valid;
  logic [31:0] s_pc, s_rs1_data, s_rs2_data, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [3:0]  s_funct;
  logic s_branch, s_memRead, s_memToReg, s_memWrite, s_ALUSrc, s_regWrite;
  logic [1:0]  s_ALUOp;
  logic [1:0]  s_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_branch(id_branch), .id_memRead(id_memRead), .id_memToReg(id_memToReg),
    .id_ALUOp(id_ALUOp), .id_memWrite(id_memWrite), .id_ALUSrc(id_ALUSrc),
    .id_regWrite(id_regWrite), .flush(flush), .ex_hold(ex_hold),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_branch(ex_branch), .ex_memRead(ex_memRead), .ex_memToReg(ex_memToReg),
    .ex_ALUOp(ex_ALUOp), .ex_memWrite(ex_memWrite), .ex_ALUSrc(ex_ALUSrc),
    .ex_regWrite(ex_regWrite), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_branch(id_branch), .id_memRead(id_memRead), .id_memToReg(id_memToReg),
    .id_ALUOp(id_ALUOp), .id_memWrite(id_memWrite), .id_ALUSrc(id_ALUSrc),
    .id_regWrite(id_regWrite), .flush(flush), .ex_hold(ex_hold),
    .stall(s_stall), .ex_valid(s_valid), .ex_pc(s_pc),
    .ex_rs1_data(s_rs1_data), .ex_rs2_data(s_rs2_data), .ex_imm(s_imm),
    .ex_rs1(s_rs1), .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_funct(s_funct),
    .ex_branch(s_branch), .ex_memRead(s_memRead), .ex_memToReg(s_memToReg),
    .ex_ALUOp(s_ALUOp), .ex_memWrite(s_memWrite), .ex_ALUSrc(s_ALUSrc),
    .ex_regWrite(s_regWrite), .bubble_cnt(s_bubble_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        mr, mw, asrc, rw, fl, hd;
    logic        e_stall, e_valid;
    logic [31:0] e_pc;
    logic [4:0]  e_rd;
    logic        e_mr, e_mw, e_rw;
    logic [15:0] e_bub;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(logic v, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic mr, logic mw, logic asrc, logic rw,
                              logic fl, logic hd, logic es, logic ev, logic [31:0] epc,
                              logic [4:0] erd, logic emr, logic emw, logic erw,
                              logic [15:0] ebub);
    vec_t x;
    x.v = v; x.pc = pc; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
    x.mr = mr; x.mw = mw; x.asrc = asrc; x.rw = rw; x.fl = fl; x.hd = hd;
    x.e_stall = es; x.e_valid = ev; x.e_pc = epc; x.e_rd = erd;
    x.e_mr = emr; x.e_mw = emw; x.e_rw = erw; x.e_bub = ebub;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Operand data is a fixed function of pc so captured data can be checked against e_pc.
  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                       input logic mw, input logic asrc, input logic rw,
                       input logic fl, input logic hd);
    id_valid    = v;
    id_pc       = pc;
    id_rs1_data = pc + 32'd100;
    id_rs2_data = ~pc;
    id_imm      = {pc[15:0], pc[31:16]};
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_funct    = pc[5:2];
    id_branch   = 1'b0;
    id_memRead  = mr;
    id_memToReg = mr;
    id_ALUOp    = (rw & ~mr) ? 2'b10 : 2'b00;
    id_memWrite = mw;
    id_ALUSrc   = asrc;
    id_regWrite = rw;
    flush       = fl;
    ex_hold     = hd;
  endtask

  initial begin
    vecs[0]  = mk(1, 32'h100, 1, 0, 5, 1, 0, 1, 1, 0, 0,  0, 1, 32'h100, 5, 1, 0, 1, 0);
    vecs[1]  = mk(1, 32'h104, 5, 7, 6, 0, 0, 0, 1, 0, 0,  1, 0, 32'h104, 6, 0, 0, 0, 1);
    vecs[2]  = mk(1, 32'h104, 5, 7, 6, 0, 0, 0, 1, 0, 0,  0, 1, 32'h104, 6, 0, 0, 1, 1);
    vecs[3]  = mk(1, 32'h108, 1, 0, 5, 1, 0, 1, 1, 0, 0,  0, 1, 32'h108, 5, 1, 0, 1, 1);
    vecs[4]  = mk(1, 32'h10c, 1, 5, 6, 0, 0, 1, 1, 0, 0,  0, 1, 32'h10c, 6, 0, 0, 1, 1);
    vecs[5]  = mk(1, 32'h110, 1, 0, 0, 1, 0, 1, 1, 0, 0,  0, 1, 32'h110, 0, 1, 0, 1, 1);
    vecs[6]  = mk(1, 32'h114, 0, 0, 6, 0, 0, 0, 1, 0, 0,  0, 1, 32'h114, 6, 0, 0, 1, 1);
    vecs[7]  = mk(1, 32'h118, 1, 0, 5, 1, 0, 1, 1, 0, 0,  0, 1, 32'h118, 5, 1, 0, 1, 1);
    vecs[8]  = mk(1, 32'h11c, 2, 5, 0, 0, 1, 1, 0, 0, 0,  1, 0, 32'h11c, 0, 0, 0, 0, 2);
    vecs[9]  = mk(1, 32'h11c, 2, 5, 0, 0, 1, 1, 0, 0, 0,  0, 1, 32'h11c, 0, 0, 1, 0, 2);
    vecs[10] = mk(1, 32'h120, 1, 0, 5, 1, 0, 1, 1, 0, 0,  0, 1, 32'h120, 5, 1, 0, 1, 2);
    vecs[11] = mk(1, 32'h124, 5, 7, 6, 0, 0, 0, 1, 1, 0,  0, 0, 32'h124, 6, 0, 0, 0, 2);
    vecs[12] = mk(0, 32'h128, 5, 7, 6, 0, 1, 0, 1, 0, 0,  0, 0, 32'h128, 6, 0, 0, 0, 2);
    vecs[13] = mk(1, 32'h130, 1, 0, 5, 1, 0, 1, 1, 0, 0,  0, 1, 32'h130, 5, 1, 0, 1, 2);
    vecs[14] = mk(1, 32'h134, 5, 7, 6, 0, 0, 0, 1, 1, 1,  1, 1, 32'h130, 5, 1, 0, 1, 2);
    vecs[15] = mk(1, 32'h138, 1, 2, 7, 0, 0, 1, 1, 0, 1,  1, 1, 32'h130, 5, 1, 0, 1, 2);
    vecs[16] = mk(1, 32'h13c, 5, 7, 6, 0, 0, 0, 1, 0, 1,  1, 1, 32'h130, 5, 1, 0, 1, 2);
    vecs[17] = mk(1, 32'h140, 1, 5, 7, 0, 0, 1, 1, 0, 0,  0, 1, 32'h140, 7, 0, 0, 1, 2);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_pc", ex_pc, 32'd0);
    chk("reset_bubble", {16'd0, bubble_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].mr,
            vecs[i].mw, vecs[i].asrc, vecs[i].rw, vecs[i].fl, vecs[i].hd);
      #1;
      chk($sformatf("v%0d_stall", i), {31'd0, stall}, {31'd0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, ex_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_pc", i), ex_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_rs1_data", i), ex_rs1_data, vecs[i].e_pc + 32'd100);
      chk($sformatf("v%0d_rs2_data", i), ex_rs2_data, ~vecs[i].e_pc);
      chk($sformatf("v%0d_rd", i), {27'd0, ex_rd}, {27'd0, vecs[i].e_rd});
      chk($sformatf("v%0d_memRead", i), {31'd0, ex_memRead}, {31'd0, vecs[i].e_mr});
      chk($sformatf("v%0d_memToReg", i), {31'd0, ex_memToReg}, {31'd0, vecs[i].e_mr});
      chk($sformatf("v%0d_memWrite", i), {31'd0, ex_memWrite}, {31'd0, vecs[i].e_mw});
      chk($sformatf("v%0d_regWrite", i), {31'd0, ex_regWrite}, {31'd0, vecs[i].e_rw});
      chk($sformatf("v%0d_bubble", i), {16'd0, bubble_cnt}, {16'd0, vecs[i].e_bub});
      $display("vec %0d: pc=0x%0h stall=%0b ex_valid=%0b ex_pc=0x%0h bubble_cnt=%0d",
               i, vecs[i].pc, stall, ex_valid, ex_pc, bubble_cnt);
    end

    // Reset asserted while a load-use stall is pending: everything clears before the next edge.
    @(negedge clk);
    drive(1, 32'h200, 1, 0, 5, 1, 0, 1, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 32'h204, 5, 7, 6, 0, 0, 0, 1, 0, 0);
    #1;
    chk("midrst_pre_stall", {31'd0, stall}, 32'd1);
    chk("midrst_pre_regWrite", {31'd0, ex_regWrite}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_stall", {31'd0, stall}, 32'd0);
    chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
    chk("midrst_regWrite", {31'd0, ex_regWrite}, 32'd0);
    chk("midrst_memRead", {31'd0, ex_memRead}, 32'd0);
    chk("midrst_pc", ex_pc, 32'd0);
    chk("midrst_rs1_data", ex_rs1_data, 32'd0);
    chk("midrst_rd", {27'd0, ex_rd}, 32'd0);
    chk("midrst_bubble", {16'd0, bubble_cnt}, 32'd0);
    $display("mid-stall reset: stall=%0b ex_valid=%0b bubble_cnt=%0d", stall, ex_valid, bubble_cnt);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // Repeated load/use pairs: the 2-bit counter saturates at 3, the 16-bit one keeps counting.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive(1, 32'h300 + 32'(8 * i), 1, 0, 5, 1, 0, 1, 1, 0, 0);
      @(posedge clk);
      @(negedge clk);
      drive(1, 32'h304 + 32'(8 * i), 5, 7, 6, 0, 0, 0, 1, 0, 0);
      #1;
      chk($sformatf("sat%0d_stall", i), {31'd0, s_stall}, 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d_cnt2", i), {30'd0, s_bubble_cnt}, (i < 2) ? 32'(i + 1) : 32'd3);
      chk($sformatf("sat%0d_cnt16", i), {16'd0, bubble_cnt}, 32'(i + 1));
      $display("saturation hazard %0d: bubble_cnt(W=2)=%0d bubble_cnt(W=16)=%0d",
               i + 1, s_bubble_cnt, bubble_cnt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
